vga_timing_gen: RTL and testbench

//  Raster timing source for the VGA controller. Divides the 100 MHz board clock to the pixel rate
//  and runs the horizontal/vertical scan counters. Drives hsync/vsync to the connector, and

---
 rtl/vga_timing_gen_pkg.sv | 47 ++++
 rtl/vga_timing_gen_pixel_tick.sv | 43 ++++
 rtl/vga_timing_gen.sv | 135 +++++++++++++
 tb/tb_vga_timing_gen.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_gen_pkg.sv
// Shared constants, types and helpers for the VGA raster timing block.
//   - Default 640x480 timing values, used as the top-level parameter defaults
//   - Fixed 10-bit scan count width and the 1024 limit on line/frame totals
//   - Packed sync payload type and small window/polarity helpers
package vga_timing_gen_pkg;

    localparam int unsigned COUNT_W     = 10;
    localparam int unsigned CMP_W       = COUNT_W + 1;  // one spare bit so a window end of 1024 still compares
    localparam int unsigned DIV_W       = 4;            // holds CLK_DIV-1 for CLK_DIV up to 16
    localparam int unsigned MAX_TOTAL   = 1024;
    localparam int unsigned MAX_CLK_DIV = 16;

    localparam int unsigned DEF_CLK_DIV   = 4;
    localparam int unsigned DEF_H_DISPLAY = 640;
    localparam int unsigned DEF_H_FRONT   = 16;
    localparam int unsigned DEF_H_SYNC    = 96;
    localparam int unsigned DEF_H_BACK    = 48;
    localparam int unsigned DEF_V_DISPLAY = 480;
    localparam int unsigned DEF_V_FRONT   = 10;
    localparam int unsigned DEF_V_SYNC    = 2;
    localparam int unsigned DEF_V_BACK    = 33;

    localparam int unsigned DEF_H_TOTAL =
        DEF_H_DISPLAY + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int unsigned DEF_V_TOTAL =
        DEF_V_DISPLAY + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

    // Registered sync/blanking payload sent to the connector and graphic generator.
    typedef struct packed {
        logic hsync;
        logic vsync;
        logic video_on;
    } vga_sync_t;

    // True when lo <= v < hi.
    function automatic logic in_window(input logic [CMP_W-1:0] v,
                                       input logic [CMP_W-1:0] lo,
                                       input logic [CMP_W-1:0] hi);
        return (v >= lo) && (v < hi);
    endfunction

    // Map an "active" flag onto the configured sync polarity.
    function automatic logic sync_level(input logic active, input logic pol);
        return active ? pol : ~pol;
    endfunction

endpackage

// File: rtl/vga_timing_gen_pixel_tick.sv
// pixel_tick_gen: divides the system clock down to the pixel rate.
//   clk    in  system clock
//   rst    in  asynchronous active-high reset
//   p_tick out registered one-clk strobe, high while the divider sits at CLK_DIV-1
// With CLK_DIV=1 the divider never leaves 0 and p_tick stays high from the
// first edge after reset release.
module pixel_tick_gen
    import vga_timing_gen_pkg::*;
#(
    parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk,
    input  logic rst,
    output logic p_tick
);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             p_tick_q,  p_tick_d;

    // Wrap-around divider; the strobe is registered off the next count.
    always_comb begin
        div_cnt_d = div_cnt_q + DIV_W'(1);
        if (div_cnt_q == DIV_LAST) begin
            div_cnt_d = '0;
        end
        p_tick_d = (div_cnt_d == DIV_LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q <= '0;
            p_tick_q  <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            p_tick_q  <= p_tick_d;
        end
    end

    assign p_tick = p_tick_q;

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster timing source for the VGA controller.
//   clk          in   system clock
//   rst          in   asynchronous active-high reset
//   hsync        out  horizontal sync, registered, polarity SYNC_POL
//   vsync        out  vertical sync, registered, polarity SYNC_POL
//   video_on     out  registered visible-area flag
//   pixel_x      out  horizontal count 0..H_TOTAL-1
//   pixel_y      out  vertical count 0..V_TOTAL-1
//   p_tick       out  one-clk strobe per pixel period
//   frame_start  out  one-clk strobe on the edge the counts wrap to (0,0)
// Sync and video_on are registered from the next count values so they change
// on the same edge as pixel_x/pixel_y.
module vga_timing_gen
    import vga_timing_gen_pkg::*;
#(
    parameter int unsigned CLK_DIV   = DEF_CLK_DIV,
    parameter int unsigned H_DISPLAY = DEF_H_DISPLAY,
    parameter int unsigned H_FRONT   = DEF_H_FRONT,
    parameter int unsigned H_SYNC    = DEF_H_SYNC,
    parameter int unsigned H_BACK    = DEF_H_BACK,
    parameter int unsigned V_DISPLAY = DEF_V_DISPLAY,
    parameter int unsigned V_FRONT   = DEF_V_FRONT,
    parameter int unsigned V_SYNC    = DEF_V_SYNC,
    parameter int unsigned V_BACK    = DEF_V_BACK,
    parameter logic        SYNC_POL  = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    output logic               hsync,
    output logic               vsync,
    output logic               video_on,
    output logic [COUNT_W-1:0] pixel_x,
    output logic [COUNT_W-1:0] pixel_y,
    output logic               p_tick,
    output logic               frame_start
);

    localparam int unsigned H_TOTAL    = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL    = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned H_SYNC_BEG = H_DISPLAY + H_FRONT;
    localparam int unsigned H_SYNC_END = H_SYNC_BEG + H_SYNC;
    localparam int unsigned V_SYNC_BEG = V_DISPLAY + V_FRONT;
    localparam int unsigned V_SYNC_END = V_SYNC_BEG + V_SYNC;

    localparam logic [COUNT_W-1:0] H_LAST = COUNT_W'(H_TOTAL - 1);
    localparam logic [COUNT_W-1:0] V_LAST = COUNT_W'(V_TOTAL - 1);

    localparam vga_sync_t SYNC_RST = '{hsync: ~SYNC_POL, vsync: ~SYNC_POL, video_on: 1'b0};

    // Elaboration-time parameter guards.
    if (H_TOTAL > MAX_TOTAL) begin : g_h_total_err
        $error("vga_timing_gen: H_TOTAL exceeds 1024");
    end
    if (V_TOTAL > MAX_TOTAL) begin : g_v_total_err
        $error("vga_timing_gen: V_TOTAL exceeds 1024");
    end
    if ((CLK_DIV == 0) || (CLK_DIV > MAX_CLK_DIV)) begin : g_clk_div_err
        $error("vga_timing_gen: CLK_DIV must be in 1..16");
    end

    logic p_tick_w;

    pixel_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_pixel_tick_gen (
        .clk    (clk),
        .rst    (rst),
        .p_tick (p_tick_w)
    );

    logic [COUNT_W-1:0] pixel_x_q, pixel_x_d;
    logic [COUNT_W-1:0] pixel_y_q, pixel_y_d;
    vga_sync_t          sync_q,    sync_d;
    logic               frame_start_q, frame_start_d;
    logic               x_last, y_last;

    // Next scan position; counts hold between pixel ticks.
    always_comb begin
        pixel_x_d     = pixel_x_q;
        pixel_y_d     = pixel_y_q;
        frame_start_d = 1'b0;
        x_last        = (pixel_x_q == H_LAST);
        y_last        = (pixel_y_q == V_LAST);

        if (p_tick_w) begin
            if (x_last) begin
                pixel_x_d = '0;
                if (y_last) begin
                    pixel_y_d     = '0;
                    frame_start_d = 1'b1;
                end else begin
                    pixel_y_d = pixel_y_q + COUNT_W'(1);
                end
            end else begin
                pixel_x_d = pixel_x_q + COUNT_W'(1);
            end
        end
    end

    // Sync/blank decode from the next counts keeps them edge-aligned with pixel_x/y.
    always_comb begin
        sync_d          = SYNC_RST;
        sync_d.hsync    = sync_level(in_window({1'b0, pixel_x_d},
                                               CMP_W'(H_SYNC_BEG),
                                               CMP_W'(H_SYNC_END)), SYNC_POL);
        sync_d.vsync    = sync_level(in_window({1'b0, pixel_y_d},
                                               CMP_W'(V_SYNC_BEG),
                                               CMP_W'(V_SYNC_END)), SYNC_POL);
        sync_d.video_on = ({1'b0, pixel_x_d} < CMP_W'(H_DISPLAY)) &&
                          ({1'b0, pixel_y_d} < CMP_W'(V_DISPLAY));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pixel_x_q     <= '0;
            pixel_y_q     <= '0;
            sync_q        <= SYNC_RST;
            frame_start_q <= 1'b0;
        end else begin
            pixel_x_q     <= pixel_x_d;
            pixel_y_q     <= pixel_y_d;
            sync_q        <= sync_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign pixel_x     = pixel_x_q;
    assign pixel_y     = pixel_y_q;
    assign hsync       = sync_q.hsync;
    assign vsync       = sync_q.vsync;
    assign video_on    = sync_q.video_on;
    assign p_tick      = p_tick_w;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen using a reduced raster (32x17 totals) so whole
// frames fit in a short run. Two instances: A (CLK_DIV=4, active-low syncs)
// and B (CLK_DIV=1, active-high syncs). A closed-form model predicts every
// output from the number of edges since reset release.
module tb_vga_timing_gen;

    localparam int HD = 16, HF = 4, HS = 6, HB = 6;
    localparam int VD = 10, VF = 2, VS = 2, VB = 3;
    localparam int HT = HD + HF + HS + HB;   // 32
    localparam int VT = VD + VF + VS + VB;   // 17
    localparam int HSS = HD + HF, HSE = HD + HF + HS;
    localparam int VSS = VD + VF, VSE = VD + VF + VS;
    localparam int DIV_A = 4;
    localparam int FRAME_A = HT * VT * DIV_A; // 2176

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       von;
        logic       pt;
        logic       fs;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       hsync_a, vsync_a, video_on_a, p_tick_a, frame_start_a;
    logic [9:0] pixel_x_a, pixel_y_a;
    logic       hsync_b, vsync_b, video_on_b, p_tick_b, frame_start_b;
    logic [9:0] pixel_x_b, pixel_y_b;

    int test_count = 0;
    int fail_count = 0;
    int cyc = 0;
    obs_t qa[$];
    obs_t qb[$];

    always #5 clk = ~clk;

    vga_timing_gen #(
        .CLK_DIV(DIV_A), .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .SYNC_POL(1'b0)
    ) dut_a (
        .clk(clk), .rst(rst), .hsync(hsync_a), .vsync(vsync_a), .video_on(video_on_a),
        .pixel_x(pixel_x_a), .pixel_y(pixel_y_a), .p_tick(p_tick_a), .frame_start(frame_start_a)
    );

    vga_timing_gen #(
        .CLK_DIV(1), .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .SYNC_POL(1'b1)
    ) dut_b (
        .clk(clk), .rst(rst), .hsync(hsync_b), .vsync(vsync_b), .video_on(video_on_b),
        .pixel_x(pixel_x_b), .pixel_y(pixel_y_b), .p_tick(p_tick_b), .frame_start(frame_start_b)
    );

    // Expected outputs after edge n (n=1 is the first edge after release).
    function automatic obs_t model(input int n, input int d, input logic pol);
        obs_t e;
        int ticks;
        logic prev_tick;
        ticks     = (d == 1) ? n - 1 : n / d;
        prev_tick = (n >= 2) && (((n - 1) % d) == d - 1);
        e.x   = 10'(ticks % HT);
        e.y   = 10'((ticks / HT) % VT);
        e.pt  = ((n % d) == d - 1);
        e.fs  = prev_tick && ((ticks % (HT * VT)) == 0);
        e.hs  = ((int'(e.x) >= HSS) && (int'(e.x) < HSE)) ? pol : ~pol;
        e.vs  = ((int'(e.y) >= VSS) && (int'(e.y) < VSE)) ? pol : ~pol;
        e.von = (int'(e.x) < HD) && (int'(e.y) < VD);
        return e;
    endfunction

    // Scoreboard: compare each queued expectation against the DUT at the falling edge.
    always @(negedge clk) begin
        obs_t e, o;
        if (qa.size() > 0) begin
            e = qa.pop_front();
            o = {pixel_x_a, pixel_y_a, hsync_a, vsync_a, video_on_a, p_tick_a, frame_start_a};
            test_count++;
            if (o !== e) begin
                fail_count++;
                $display("FAIL sb_a t=%0t got x=%0d y=%0d hs=%b vs=%b von=%b pt=%b fs=%b exp x=%0d y=%0d hs=%b vs=%b von=%b pt=%b fs=%b",
                         $time, o.x, o.y, o.hs, o.vs, o.von, o.pt, o.fs,
                         e.x, e.y, e.hs, e.vs, e.von, e.pt, e.fs);
            end
        end
        if (qb.size() > 0) begin
            e = qb.pop_front();
            o = {pixel_x_b, pixel_y_b, hsync_b, vsync_b, video_on_b, p_tick_b, frame_start_b};
            test_count++;
            if (o !== e) begin
                fail_count++;
                $display("FAIL sb_b t=%0t got x=%0d y=%0d hs=%b vs=%b von=%b pt=%b fs=%b exp x=%0d y=%0d hs=%b vs=%b von=%b pt=%b fs=%b",
                         $time, o.x, o.y, o.hs, o.vs, o.von, o.pt, o.fs,
                         e.x, e.y, e.hs, e.vs, e.von, e.pt, e.fs);
            end
        end
    end

    // Queue expectations for the coming edge, then advance one clock.
    task automatic tick();
        qa.push_back(model(cyc + 1, DIV_A, 1'b0));
        qb.push_back(model(cyc + 1, 1, 1'b1));
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic release_rst();
        @(negedge clk);
        #2;
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        test_count++;
        if ({hsync_a, vsync_a, video_on_a, p_tick_a, frame_start_a, pixel_x_a, pixel_y_a} !== {5'b11000, 20'd0}) begin
            fail_count++;
            $display("FAIL reset_a got hs=%b vs=%b von=%b pt=%b fs=%b x=%0d y=%0d exp 1 1 0 0 0 0 0",
                     hsync_a, vsync_a, video_on_a, p_tick_a, frame_start_a, pixel_x_a, pixel_y_a);
        end
        test_count++;
        if ({hsync_b, vsync_b, video_on_b, p_tick_b, frame_start_b, pixel_x_b, pixel_y_b} !== {5'b00000, 20'd0}) begin
            fail_count++;
            $display("FAIL reset_b got hs=%b vs=%b von=%b pt=%b fs=%b x=%0d y=%0d exp 0 0 0 0 0 0 0",
                     hsync_b, vsync_b, video_on_b, p_tick_b, frame_start_b, pixel_x_b, pixel_y_b);
        end

        release_rst();
        tick();
        test_count++;
        if ({video_on_a, frame_start_a, pixel_x_a, pixel_y_a} !== {2'b10, 20'd0}) begin
            fail_count++;
            $display("FAIL release_a got von=%b fs=%b x=%0d y=%0d exp von=1 fs=0 x=0 y=0",
                     video_on_a, frame_start_a, pixel_x_a, pixel_y_a);
        end

        // Run into the hsync pulse, then reset mid-pulse between edges.
        while (cyc < DIV_A * (HSS + 2) + 1) tick();
        test_count++;
        if (hsync_a !== 1'b0) begin
            fail_count++;
            $display("FAIL pre_reset_hsync got %b exp 0 (x=%0d)", hsync_a, pixel_x_a);
        end
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        test_count++;
        if ({hsync_a, vsync_a, video_on_a, p_tick_a, frame_start_a, pixel_x_a, pixel_y_a} !== {5'b11000, 20'd0}) begin
            fail_count++;
            $display("FAIL async_reset_a got hs=%b vs=%b von=%b pt=%b fs=%b x=%0d y=%0d exp 1 1 0 0 0 0 0",
                     hsync_a, vsync_a, video_on_a, p_tick_a, frame_start_a, pixel_x_a, pixel_y_a);
        end
        test_count++;
        if ({hsync_b, vsync_b, p_tick_b, pixel_x_b} !== {3'b000, 10'd0}) begin
            fail_count++;
            $display("FAIL async_reset_b got hs=%b vs=%b pt=%b x=%0d exp 0 0 0 0",
                     hsync_b, vsync_b, p_tick_b, pixel_x_b);
        end
        repeat (2) @(posedge clk);
        release_rst();
        tick();
        test_count++;
        if ({video_on_b, p_tick_b, frame_start_b, pixel_x_b} !== {3'b110, 10'd0}) begin
            fail_count++;
            $display("FAIL release_b got von=%b pt=%b fs=%b x=%0d exp von=1 pt=1 fs=0 x=0",
                     video_on_b, p_tick_b, frame_start_b, pixel_x_b);
        end
    endtask

    task automatic test_divider();
        int pa = 0, pb = 0;
        logic [9:0] x0;
        x0 = pixel_x_a;
        repeat (40) begin
            tick();
            pa += int'(p_tick_a);
            pb += int'(p_tick_b);
        end
        test_count++;
        if (pa !== 10) begin
            fail_count++;
            $display("FAIL div_a_ticks got %0d exp 10", pa);
        end
        test_count++;
        if (pb !== 40) begin
            fail_count++;
            $display("FAIL div_b_ticks got %0d exp 40", pb);
        end
        test_count++;
        if (pixel_x_a !== 10'((int'(x0) + 10) % HT)) begin
            fail_count++;
            $display("FAIL div_a_step got x=%0d exp %0d", pixel_x_a, (int'(x0) + 10) % HT);
        end
    endtask

    task automatic test_hsync();
        logic prev;
        int budget = 2 * HT * DIV_A;
        int low = 0;
        do begin
            prev = hsync_a;
            tick();
            budget--;
        end while (!(prev && !hsync_a) && budget > 0);
        test_count++;
        if (budget == 0 || pixel_x_a !== 10'(HSS)) begin
            fail_count++;
            $display("FAIL hsync_fall got x=%0d budget=%0d exp x=%0d", pixel_x_a, budget, HSS);
        end
        budget = 2 * HT * DIV_A;
        do begin
            low++;
            tick();
            budget--;
        end while (!hsync_a && budget > 0);
        test_count++;
        if (low !== HS * DIV_A || pixel_x_a !== 10'(HSE)) begin
            fail_count++;
            $display("FAIL hsync_width got low=%0d x=%0d exp low=%0d x=%0d", low, pixel_x_a, HS * DIV_A, HSE);
        end
    endtask

    task automatic test_frame();
        int budget = 2 * FRAME_A + 8;
        int cnt = 0, von = 0, vlow = 0, fsb = 0;
        while (!frame_start_a && budget > 0) begin
            tick();
            budget--;
        end
        test_count++;
        if (budget == 0 || {pixel_x_a, pixel_y_a} !== 20'd0) begin
            fail_count++;
            $display("FAIL frame_start_pos got x=%0d y=%0d budget=%0d exp x=0 y=0", pixel_x_a, pixel_y_a, budget);
        end
        budget = 2 * FRAME_A;
        do begin
            von  += int'(video_on_a);
            vlow += int'(!vsync_a);
            fsb  += int'(frame_start_b);
            tick();
            cnt++;
            budget--;
        end while (!frame_start_a && budget > 0);
        test_count++;
        if (cnt !== FRAME_A) begin
            fail_count++;
            $display("FAIL frame_period got %0d exp %0d", cnt, FRAME_A);
        end
        test_count++;
        if (von !== HD * VD * DIV_A) begin
            fail_count++;
            $display("FAIL video_on_count got %0d exp %0d", von, HD * VD * DIV_A);
        end
        test_count++;
        if (vlow !== VS * HT * DIV_A) begin
            fail_count++;
            $display("FAIL vsync_width got %0d exp %0d", vlow, VS * HT * DIV_A);
        end
        test_count++;
        if (fsb !== DIV_A) begin
            fail_count++;
            $display("FAIL frame_count_b got %0d exp %0d", fsb, DIV_A);
        end
    endtask

    task automatic test_params();
        int hsb = 0, ptb = 0;
        logic [9:0] x0, y0;
        x0 = pixel_x_b;
        y0 = pixel_y_b;
        repeat (HT) begin
            tick();
            hsb += int'(hsync_b);
            ptb += int'(p_tick_b);
        end
        test_count++;
        if (pixel_x_b !== x0 || pixel_y_b !== 10'((int'(y0) + 1) % VT)) begin
            fail_count++;
            $display("FAIL line_b got x=%0d y=%0d exp x=%0d y=%0d", pixel_x_b, pixel_y_b, x0, (int'(y0) + 1) % VT);
        end
        test_count++;
        if (hsb !== HS || ptb !== HT) begin
            fail_count++;
            $display("FAIL params_b got hs_active=%0d ticks=%0d exp %0d %0d", hsb, ptb, HS, HT);
        end
    endtask

    initial begin
        test_reset();
        test_divider();
        test_hsync();
        test_frame();
        test_params();
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
